ex_mem_flag_stage: RTL and testbench

EX_MEM_FLAG_STAGE -- requirements
Module: ex_mem_flag_stage

---
 rtl/ex_mem_flag_stage.sv | 98 +++++++++
 tb/tb_ex_mem_flag_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with an architectural N/Z/V flag register and a
// saturating count of committed ADD/SUB overflows.
module ex_mem_flag_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [3:0]  ex_op,
    input  logic [15:0] ex_alu_result,
    input  logic        ex_ovfl,
    input  logic [3:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [15:0] ex_store_data,
    output logic        mem_valid,
    output logic        mem_reg_write,
    output logic        mem_mem_read,
    output logic        mem_mem_write,
    output logic [15:0] mem_alu_result,
    output logic [15:0] mem_store_data,
    output logic [3:0]  mem_rd,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_v,
    output logic [15:0] ovfl_count
);

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpXor = 4'b0010;
    localparam logic [3:0] OpSll = 4'b0100;
    localparam logic [3:0] OpSra = 4'b0101;
    localparam logic [3:0] OpRor = 4'b0110;

    logic upd_z;
    logic upd_nv;
    logic cnt_inc;

    // RED, PADDSB and non-ALU opcodes touch no flags.
    always_comb begin
        upd_nv  = 1'b0;
        upd_z   = 1'b0;
        unique case (ex_op)
            OpAdd, OpSub: begin
                upd_nv = ex_valid;
                upd_z  = ex_valid;
            end
            OpXor, OpSll, OpSra, OpRor: upd_z = ex_valid;
            default: ;
        endcase
        cnt_inc = upd_nv && ex_ovfl && (ovfl_count != 16'hFFFF);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_alu_result <= 16'h0000;
            mem_store_data <= 16'h0000;
            mem_rd         <= 4'h0;
            flag_n         <= 1'b0;
            flag_z         <= 1'b0;
            flag_v         <= 1'b0;
            ovfl_count     <= 16'h0000;
        end else if (flush) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_alu_result <= 16'h0000;
            mem_store_data <= 16'h0000;
            mem_rd         <= 4'h0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_reg_write  <= ex_reg_write;
            mem_mem_read   <= ex_mem_read;
            mem_mem_write  <= ex_mem_write;
            mem_alu_result <= ex_alu_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            if (upd_z) begin
                flag_z <= (ex_alu_result == 16'h0000);
            end
            if (upd_nv) begin
                flag_n <= ex_alu_result[15];
                flag_v <= ex_ovfl;
            end
            if (cnt_inc) begin
                ovfl_count <= ovfl_count + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Bench for ex_mem_flag_stage: directed scenarios plus random traffic, all
// compared against a behavioural model of the stage and flag rules.
module tb_ex_mem_flag_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, ex_valid, ex_ovfl;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [3:0]  ex_op, ex_rd;
    logic [15:0] ex_alu_result, ex_store_data;
    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
    logic [15:0] mem_alu_result, mem_store_data, ovfl_count;
    logic [3:0]  mem_rd;
    logic        flag_n, flag_z, flag_v;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic        m_valid, m_rw, m_mr, m_mw, m_n, m_z, m_v;
    logic [15:0] m_alu, m_sd;
    logic [3:0]  m_rd;
    int          m_cnt;

    always #5 clk = ~clk;

    ex_mem_flag_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_alu_result(ex_alu_result),
        .ex_ovfl(ex_ovfl), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data), .mem_valid(mem_valid),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd), .flag_n(flag_n),
        .flag_z(flag_z), .flag_v(flag_v), .ovfl_count(ovfl_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Spec-level model of one clock edge, evaluated from the inputs present at the edge.
    task automatic model_edge();
        int op;
        op = int'(ex_op);
        if (!rst_n) begin
            {m_valid, m_rw, m_mr, m_mw, m_n, m_z, m_v} = '0;
            m_alu = 0; m_sd = 0; m_rd = 0; m_cnt = 0;
        end else if (flush) begin
            {m_valid, m_rw, m_mr, m_mw} = '0;
            m_alu = 0; m_sd = 0; m_rd = 0;
        end else if (!stall) begin
            m_valid = ex_valid; m_rw = ex_reg_write; m_mr = ex_mem_read;
            m_mw = ex_mem_write; m_alu = ex_alu_result; m_sd = ex_store_data;
            m_rd = ex_rd;
            if (ex_valid) begin
                if (op == 0 || op == 1) begin
                    m_z = (ex_alu_result == 0);
                    m_n = (ex_alu_result >= 16'h8000);
                    m_v = ex_ovfl;
                    if (ex_ovfl && m_cnt < 65535) m_cnt = m_cnt + 1;
                end else if (op == 2 || op == 4 || op == 5 || op == 6) begin
                    m_z = (ex_alu_result == 0);
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 16'(mem_valid), 16'(m_valid));
        chk({tag, ".ctl"}, 16'({mem_reg_write, mem_mem_read, mem_mem_write}),
            16'({m_rw, m_mr, m_mw}));
        chk({tag, ".alu"}, mem_alu_result, m_alu);
        chk({tag, ".sd"}, mem_store_data, m_sd);
        chk({tag, ".rd"}, 16'(mem_rd), 16'(m_rd));
        chk({tag, ".nzv"}, 16'({flag_n, flag_z, flag_v}), 16'({m_n, m_z, m_v}));
        chk({tag, ".cnt"}, ovfl_count, 16'(m_cnt));
    endtask

    // Apply current inputs across one rising edge and sample 1 time unit later.
    task automatic tick(input string tag, input bit do_check);
        @(posedge clk);
        model_edge();
        #1;
        if (do_check) check_all(tag);
    endtask

    task automatic set_ex(input logic v, input logic [3:0] op, input logic [15:0] res,
                          input logic ov);
        ex_valid = v; ex_op = op; ex_alu_result = res; ex_ovfl = ov;
        ex_rd = 4'($urandom); ex_reg_write = 1'($urandom);
        ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
        ex_store_data = 16'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_ex(1'b1, 4'h0, 16'h1234, 1'b1);
        #2;
        tick("reset0", 1'b0);
        tick("reset", 1'b1);
        chk("reset.cnt_zero", ovfl_count, 16'h0000);
        rst_n = 1'b1;

        // ADD 0x7FFF with saturation
        set_ex(1'b1, 4'h0, 16'h7FFF, 1'b1);
        tick("add", 1'b1);
        chk("add.alu", mem_alu_result, 16'h7FFF);
        chk("add.valid", 16'(mem_valid), 16'h1);
        chk("add.nzv", 16'({flag_n, flag_z, flag_v}), 16'b001);
        chk("add.cnt", ovfl_count, 16'h0001);

        set_ex(1'b1, 4'h1, 16'h0000, 1'b0);
        tick("sub", 1'b1);
        chk("sub.nzv", 16'({flag_n, flag_z, flag_v}), 16'b010);
        set_ex(1'b1, 4'h2, 16'h8000, 1'b1);
        tick("xor", 1'b1);
        chk("xor.nzv", 16'({flag_n, flag_z, flag_v}), 16'b000);
        chk("xor.cnt", ovfl_count, 16'h0001);

        // Set n=1,v=1,z=0, then PADDSB with zero result must not touch flags
        set_ex(1'b1, 4'h0, 16'h8000, 1'b1);
        tick("add_neg", 1'b1);
        set_ex(1'b1, 4'h7, 16'h0000, 1'b1);
        tick("paddsb", 1'b1);
        chk("paddsb.nzv", 16'({flag_n, flag_z, flag_v}), 16'b101);
        chk("paddsb.alu", mem_alu_result, 16'h0000);
        chk("paddsb.cnt", ovfl_count, 16'h0002);

        // Stall for three cycles with changing EX inputs
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, 4'(i), 16'($urandom), 1'b1);
            tick("stall", 1'b1);
            chk("stall.alu", mem_alu_result, 16'h0000);
            chk("stall.cnt", ovfl_count, 16'h0002);
        end
        flush = 1'b1;
        set_ex(1'b1, 4'h1, 16'h0000, 1'b1);
        tick("stallflush", 1'b1);
        chk("stallflush.valid", 16'(mem_valid), 16'h0);
        chk("stallflush.nzv", 16'({flag_n, flag_z, flag_v}), 16'b101);
        stall = 1'b0; flush = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_ex(1'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0 :
                   16'($urandom), 1'($urandom));
            tick("rand", 1'b1);
        end

        // Saturation of the overflow counter
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        tick("sat_reset", 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            set_ex(1'b1, 4'(i % 2), 16'h7FFF, 1'b1);
            tick("preload", 1'b0);
        end
        chk("preload.cnt", ovfl_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, 4'h0, 16'h7FFF, 1'b1);
            tick("sat", 1'b1);
            chk("sat.cnt", ovfl_count, 16'hFFFF);
        end
        rst_n = 1'b0; stall = 1'b1;
        tick("final_reset", 1'b1);
        chk("final_reset.all", {mem_alu_result | mem_store_data | ovfl_count},
            16'h0000);
        chk("final_reset.bits", 16'({mem_valid, mem_reg_write, mem_mem_read,
            mem_mem_write, mem_rd, flag_n, flag_z, flag_v}), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
